// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between a requester (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// RV32 byte/half/word lane handling: store byte enables and lane replication,
// load lane select with sign/zero extension. DMEM_MISALIGN_TRAP_EN enables error flagging.
module lsu_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [2:0]         w_f3;
  logic [1:0]         w_off;
  logic [31:0]        w_shift;
  logic signed [7:0]  w_lb;
  logic signed [15:0] w_lh;

  always_comb begin
    w_f3       = i_funct3;
    w_off      = i_addr;
    o_misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!f3_legal(i_funct3) || (i_we && i_funct3[2]))
      o_misalign = 1'b1;
    else if ((i_funct3[1:0] == 2'b01) && i_addr[0])
      o_misalign = 1'b1;
    else if ((i_funct3 == F3_W) && (i_addr != 2'b00))
      o_misalign = 1'b1;
`else
    // Without trapping, illegal sizes fall back to a word and bad offsets are aligned down.
    if (!f3_legal(i_funct3))
      w_f3 = F3_W;
    else if (i_we)
      w_f3 = {1'b0, i_funct3[1:0]};
    if (w_f3[1:0] == 2'b01)
      w_off = {i_addr[1], 1'b0};
    else if (w_f3[1:0] == 2'b10)
      w_off = 2'b00;
`endif
  end

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    case (w_f3[1:0])
      2'b00: begin
        o_byte_en = 4'b0001 << w_off;
        o_wdata   = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_byte_en = 4'b0011 << {w_off[1], 1'b0};
        o_wdata   = {2{i_wdata[15:0]}};
      end
      default: begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
      end
    endcase
    if (o_misalign || !i_we)
      o_byte_en = 4'b0000;
  end

  always_comb begin
    w_shift = i_raw >> {w_off, 3'b000};
    w_lb    = w_shift[7:0];
    w_lh    = w_shift[15:0];
    case (w_f3)
      F3_B:    o_rdata = 32'(w_lb);
      F3_H:    o_rdata = 32'(w_lh);
      F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response after LATENCY wait cycles.
// Build with DMEM_MISALIGN_TRAP_EN to report misaligned/illegal accesses on resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_C = LAT_W'(LATENCY);

  logic [31:0]      r_mem [DEPTH_WORDS];
  state_t           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic             r_we;
  logic [AW+1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic [2:0]       r_funct3;

  logic [AW-1:0]    w_idx;
  logic [31:0]      w_raw;
  logic [3:0]       w_be;
  logic [31:0]      w_st;
  logic [31:0]      w_ld;
  logic             w_misalign;
  logic             w_commit;
  logic             w_unused;

  // Address bits above the index alias onto the same word.
  assign w_unused = &{1'b0, bus.req_addr[31:AW+2]};
  assign w_idx    = r_addr[AW+1:2];
  assign w_raw    = r_mem[w_idx];
  // One cycle to capture the request, then LATENCY wait cycles, then commit.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == LAT_C);

  lsu_lane_align u_align (
    .i_addr     (r_addr[1:0]),
    .i_funct3   (r_funct3),
    .i_we       (r_we),
    .i_wdata    (r_wdata),
    .i_raw      (w_raw),
    .o_byte_en  (w_be),
    .o_wdata    (w_st),
    .o_rdata    (w_ld),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr[AW+1:0];
            r_wdata     <= bus.req_wdata;
            r_funct3    <= bus.req_funct3;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_commit) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_misalign;
            r_resp_rdata <= (w_misalign || r_we) ? 32'd0 : w_ld;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // A reset on the commit edge abandons the store.
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_st[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder with a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] mdl [DEPTH];

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32 load/store semantics on a plain word array.
  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
    logic [2:0]  g;
    logic [31:0] a;
    logic [31:0] mask;
    bit          legal;
    int          size;
    int          off;
    int          idx;
    g = f3;
    a = addr;
    rd = 32'd0;
    er = 1'b0;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!legal || (we && f3[2]) || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ||
        (f3 == 3'd2 && a[1:0] != 2'b00)) begin
      er = 1'b1;
      return;
    end
`else
    if (!legal) g = 3'd2;
    if (we) g[2] = 1'b0;
    if (g[1:0] == 2'd1) a[0] = 1'b0;
    if (g[1:0] == 2'd2) a[1:0] = 2'b00;
`endif
    size = (g[1:0] == 2'd0) ? 1 : (g[1:0] == 2'd1) ? 2 : 4;
    idx  = int'((a / 4) % DEPTH);
    off  = int'(a % 4);
    if (we) begin
      for (int k = 0; k < size; k++)
        mdl[idx][8*(off+k) +: 8] = wdata[8*k +: 8];
    end else begin
      rd = mdl[idx] >> (8 * off);
      if (size < 4) begin
        mask = (32'h1 << (8 * size)) - 32'h1;
        rd = rd & mask;
        if (!g[2] && rd[8*size-1]) rd = rd | ~mask;
      end
    end
  endfunction

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold, input bit pulse,
                        output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          cyc;
    int          w;
    bit          got;
    model(we, addr, wdata, f3, exp_rd, exp_er);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (pulse) begin
      bus.req_we   = 1'b1;
      bus.req_addr = 32'h300;
    end else begin
      bus.req_valid = 1'b0;
    end
    bus.resp_ready = (hold == 0);
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      got = bus.resp_valid;
    end
    bus.req_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(LAT + 1));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    chk("rdata", rd, exp_rd);
    chk("err", {31'd0, er}, {31'd0, exp_er});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_rdata", bus.resp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_drop", {31'd0, bus.resp_valid}, 32'd0);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    if (pulse) begin
      repeat (2) begin
        @(posedge clk);
        #1;
        chk("no_extra_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("still_idle", {31'd0, bus.req_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] v;
    logic [31:0] a;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    reset = 1'b0;

    do_req(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("lw_100", rd, 32'hDEADBEEF);

    do_req(1'b1, 32'h103, 32'h00000080, 3'b000, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h103, 32'd0, 3'b000, 0, 1'b0, rd, er);
    chk("lb_103", rd, 32'hFFFFFF80);
    do_req(1'b0, 32'h103, 32'd0, 3'b100, 0, 1'b0, rd, er);
    chk("lbu_103", rd, 32'h00000080);
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("lw_after_sb", rd, 32'h80ADBEEF);

    do_req(1'b1, 32'h102, 32'h00001234, 3'b001, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h102, 32'd0, 3'b101, 0, 1'b0, rd, er);
    chk("lhu_102", rd, 32'h00001234);
    do_req(1'b0, 32'h100, 32'd0, 3'b001, 0, 1'b0, rd, er);
    chk("lh_100", rd, 32'hFFFFBEEF);

    do_req(1'b1, 32'h101, 32'h00000055, 3'b010, 0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("sw_mis_err", {31'd0, er}, 32'd1);
    chk("sw_mis_rdata", rd, 32'd0);
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("lw_after_mis", rd, 32'h1234BEEF);
    do_req(1'b0, 32'h100, 32'd0, 3'b011, 0, 1'b0, rd, er);
    chk("f3_011_err", {31'd0, er}, 32'd1);
`else
    chk("sw_mis_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("lw_after_mis", rd, 32'h00000055);
    do_req(1'b0, 32'h100, 32'd0, 3'b011, 0, 1'b0, rd, er);
    chk("f3_011_as_w", rd, 32'h00000055);
`endif

    // Backpressure in RESP with request pulses during WAIT.
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 5, 1'b1, rd, er);

    // Reset during WAIT abandons the store.
    do_req(1'b1, 32'h200, 32'h11112222, 3'b010, 0, 1'b0, rd, er);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'hAAAA5555;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("rst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    chk("rst_idle", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, 32'h200, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("lw_200_kept", rd, 32'h11112222);

    v = $urandom;
    do_req(1'b1, 32'h100 + 32'(4 * DEPTH), v, 3'b010, 0, 1'b0, rd, er);
    do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er);
    chk("alias_100", rd, v);

    for (int k = 0; k < 8; k++)
      do_req(1'b1, 32'h400 + 32'(4 * k), $urandom, 3'b010, 0, 1'b0, rd, er);
    for (int n = 0; n < 60; n++) begin
      a = 32'h400 + 32'($urandom_range(0, 31));
      do_req(1'($urandom % 2), a, $urandom, 3'($urandom % 8),
             ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder: the memory-side end of the datapath's load/store interface. It accepts one request at a time through a valid/ready handshake and returns load data through a separate response handshake after a programmable wait latency. It performs RV32 byte/half/word lane handling itself: store byte-lane merging, and load sign/zero extension selected by funct3. Target is the multicycle core and cache-less test SoC; the single-cycle core stays on its combinational memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two; index = addr[log2(DEPTH_WORDS)+1:2].
LATENCY, 1, wait cycles between accept and response (0..15).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept (IDLE only)
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (rs2 value)
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal funct3

Behaviour:
- Reset (clk edge with reset=1): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not cleared.
- States:
  - IDLE: req_ready=1. If req_valid, latch we/addr/wdata/funct3. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: counter counts up to LATENCY; req_ready=0. On the last wait cycle, go to RESP.
  - RESP: resp_valid=1, and resp_rdata/resp_err stay stable until resp_ready=1. Then go to IDLE; resp_valid drops the following cycle.
- Latency: accept at edge N; resp_valid rises at edge N+1+LATENCY. Minimum one idle bubble between back-to-back requests.
- Store commit: the memory write happens on the edge entering RESP, with byte enables:
  - SB: one lane at addr[1:0].
  - SH: lanes {addr[1],0} and {addr[1],1}.
  - SW: all four lanes.
  - Data is replicated/shifted into the lane.
- Load: the word is read on the edge entering RESP. The lane is selected by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU).
- Errors: resp_err=1 when any of these hold:
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - funct3 in {011, 110, 111}
  - store with funct3[2]=1
  On error, no memory write occurs and rdata=0. The error still goes through the full latency and handshake.
- Upper address bits above the index are ignored (wrap-around aliasing).
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.
- Reset mid-operation (WAIT or RESP) abandons the request. A pending store is not written. No response is issued.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: error detection as above.
- Undefined: resp_err tied 0. Misaligned H/W accesses are forced aligned by clearing the offending low address bits. Illegal funct3 is treated as W.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum {S_IDLE, S_WAIT, S_RESP}
  - counter width constant LAT_W=4
- One combinational sub-module, lsu_lane_align:
  - inputs: addr[1:0], funct3, we, wdata, raw word
  - outputs: byte_en[3:0], shifted store data, extended load data, misalign flag
- The FSM and storage array live in dmem_responder.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x100, then LW @0x100 -> resp_valid exactly 2 cycles after each accept; rdata 0xDEADBEEF, err 0.
- SB 0x80 @0x103, then LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080; LW @0x100 -> 0x80ADBEEF.
- SH 0x1234 @0x102, then LHU @0x102 -> 0x00001234; LH @0x100 -> 0xFFFFBEEF (lower half unchanged).
- With DMEM_MISALIGN_TRAP_EN: SW 0x55 @0x101 -> err 1, rdata 0; then LW @0x100 -> unchanged. funct3=011 -> err 1. Without the macro, the SW writes @0x100.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0; release -> IDLE next cycle. req_valid pulses during WAIT are not accepted.
- Assert reset during WAIT of SW 0xAAAA5555 @0x200 -> no response; LW @0x200 afterwards returns the prior contents. Also: address 0x100 + 4*DEPTH_WORDS aliases 0x100.
